// File: rtl/pe_store_writeback.sv
`default_nettype none
// ============================================================================
// Module   : pe_store_writeback
// Purpose  : Snapshot the four PE result words on one store command and
//            write the PE-enabled ones into data BRAM port B at consecutive
//            addresses, one word per clock, then pulse STORE_DONE.
// Option   : STORE_VERIFY_EN - read every written word back and flag any
//            mismatch on VERIFY_ERR.
// Revision : 1.0 - initial release
// ============================================================================
module pe_store_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              STORE_START,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [3:0]        PE_MASK,
    input  logic [DATA_W-1:0] PE_DOUT_0,
    input  logic [DATA_W-1:0] PE_DOUT_1,
    input  logic [DATA_W-1:0] PE_DOUT_2,
    input  logic [DATA_W-1:0] PE_DOUT_3,
    output logic [ADDR_W-1:0] addrb,
    output logic [DATA_W-1:0] dinb,
    input  logic [DATA_W-1:0] doutb,
    output logic              enb,
    output logic [3:0]        web,
    output logic              STORE_BUSY,
    output logic              STORE_DONE,
    output logic [2:0]        WORDS_WRITTEN,
    output logic              VERIFY_ERR
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WRITE      = 3'd1,
        S_DONE       = 3'd2
`ifdef STORE_VERIFY_EN
        ,
        S_VERIFY_RD  = 3'd3,
        S_VERIFY_CMP = 3'd4
`endif
    } state_t;

    // Index of the lowest set bit; 0 for an empty mask (never used then).
    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Registered state. Every output is driven from a register that is
    // loaded with the value belonging to the state being entered, so the
    // outputs are always aligned with the current state.
    state_t              r_state;
    logic [3:0]          r_pend;      // PEs not yet presented to the BRAM
    logic [2:0]          r_k;         // index of the word currently presented
    logic [ADDR_W-1:0]   r_base;
    logic [DATA_W-1:0]   r_snap [4];
    logic [ADDR_W-1:0]   r_addrb;
    logic [DATA_W-1:0]   r_dinb;
    logic                r_enb;
    logic [3:0]          r_web;
    logic                r_busy;
    logic                r_done;
    logic [2:0]          r_words;

    // Next-state values
    state_t              w_state_n;
    logic [3:0]          w_pend_n;
    logic [2:0]          w_k_n;
    logic [2:0]          w_words_n;
    logic [ADDR_W-1:0]   w_addrb_n;
    logic [DATA_W-1:0]   w_dinb_n;
    logic                w_enb_n;
    logic [3:0]          w_web_n;
    logic                w_cap;
    logic [1:0]          w_first;
    logic [1:0]          w_next;
    logic [DATA_W-1:0]   w_pe_in [4];

`ifdef STORE_VERIFY_EN
    logic [1:0]          r_slot [4];  // PE index stored at BASE+k
    logic                r_verr;
    logic                w_verr_n;
    logic                w_slot_we;
    logic [1:0]          w_slot_pe;
    logic [2:0]          w_km1;
`else
    logic                w_unused_doutb;
    assign w_unused_doutb = ^doutb;
`endif

    assign w_pe_in[0] = PE_DOUT_0;
    assign w_pe_in[1] = PE_DOUT_1;
    assign w_pe_in[2] = PE_DOUT_2;
    assign w_pe_in[3] = PE_DOUT_3;

    assign w_first = lowest_set(PE_MASK);
    assign w_next  = lowest_set(r_pend);

    // Next-state and next-output decode
    always_comb begin
        w_state_n = r_state;
        w_pend_n  = r_pend;
        w_k_n     = r_k;
        w_words_n = r_words;
        w_addrb_n = '0;
        w_dinb_n  = '0;
        w_enb_n   = 1'b0;
        w_web_n   = 4'b0000;
        w_cap     = 1'b0;
`ifdef STORE_VERIFY_EN
        w_verr_n  = r_verr;
        w_slot_we = 1'b0;
        w_slot_pe = 2'd0;
        w_km1     = r_k - 3'd1;
`endif
        case (r_state)
            S_IDLE: begin
                if (STORE_START) begin
                    w_cap     = 1'b1;
                    w_k_n     = 3'd0;
                    w_words_n = 3'd0;
`ifdef STORE_VERIFY_EN
                    w_verr_n  = 1'b0;
`endif
                    if (PE_MASK == 4'b0000) begin
                        w_pend_n  = 4'b0000;
                        w_state_n = S_DONE;
                    end else begin
                        // First word comes straight from the live inputs,
                        // which are being snapshotted on this same edge.
                        w_state_n = S_WRITE;
                        w_enb_n   = 1'b1;
                        w_web_n   = 4'b1111;
                        w_addrb_n = BASE_ADDR;
                        w_dinb_n  = w_pe_in[w_first];
                        w_pend_n  = PE_MASK & ~(4'b0001 << w_first);
`ifdef STORE_VERIFY_EN
                        w_slot_we = 1'b1;
                        w_slot_pe = w_first;
`endif
                    end
                end
            end
            S_WRITE: begin
                // The presented word is committed at the end of this cycle.
                w_words_n = r_words + 3'd1;
                if (r_pend == 4'b0000) begin
`ifdef STORE_VERIFY_EN
                    w_state_n = S_VERIFY_RD;
                    w_k_n     = 3'd0;
                    w_enb_n   = 1'b1;
                    w_addrb_n = r_base;
`else
                    w_state_n = S_DONE;
`endif
                end else begin
                    w_k_n     = r_k + 3'd1;
                    w_enb_n   = 1'b1;
                    w_web_n   = 4'b1111;
                    w_addrb_n = r_base + ADDR_W'(w_k_n);
                    w_dinb_n  = r_snap[w_next];
                    w_pend_n  = r_pend & ~(4'b0001 << w_next);
`ifdef STORE_VERIFY_EN
                    w_slot_we = 1'b1;
                    w_slot_pe = w_next;
`endif
                end
            end
`ifdef STORE_VERIFY_EN
            S_VERIFY_RD: begin
                // doutb now carries the word read in the previous cycle.
                if (r_k != 3'd0 && doutb != r_snap[r_slot[w_km1[1:0]]]) begin
                    w_verr_n = 1'b1;
                end
                if (r_k + 3'd1 == r_words) begin
                    w_state_n = S_VERIFY_CMP;
                end else begin
                    w_k_n     = r_k + 3'd1;
                    w_enb_n   = 1'b1;
                    w_addrb_n = r_base + ADDR_W'(w_k_n);
                end
            end
            S_VERIFY_CMP: begin
                if (doutb != r_snap[r_slot[r_k[1:0]]]) begin
                    w_verr_n = 1'b1;
                end
                w_state_n = S_DONE;
            end
`endif
            S_DONE: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // State, snapshot and registered-output update
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_pend  <= 4'b0000;
            r_k     <= 3'd0;
            r_base  <= '0;
            for (int i = 0; i < 4; i++) begin
                r_snap[i] <= '0;
            end
            r_addrb <= '0;
            r_dinb  <= '0;
            r_enb   <= 1'b0;
            r_web   <= 4'b0000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_words <= 3'd0;
        end else begin
            r_state <= w_state_n;
            r_pend  <= w_pend_n;
            r_k     <= w_k_n;
            r_addrb <= w_addrb_n;
            r_dinb  <= w_dinb_n;
            r_enb   <= w_enb_n;
            r_web   <= w_web_n;
            r_busy  <= (w_state_n != S_IDLE);
            r_done  <= (w_state_n == S_DONE);
            r_words <= w_words_n;
            if (w_cap) begin
                r_base    <= BASE_ADDR;
                r_snap[0] <= PE_DOUT_0;
                r_snap[1] <= PE_DOUT_1;
                r_snap[2] <= PE_DOUT_2;
                r_snap[3] <= PE_DOUT_3;
            end
        end
    end

`ifdef STORE_VERIFY_EN
    // Record which PE landed at each address and track readback errors
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_verr <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_slot[i] <= 2'd0;
            end
        end else begin
            r_verr <= w_verr_n;
            if (w_slot_we) begin
                r_slot[w_k_n[1:0]] <= w_slot_pe;
            end
        end
    end

    assign VERIFY_ERR = r_verr;
`else
    assign VERIFY_ERR = 1'b0;
`endif

    assign addrb         = r_addrb;
    assign dinb          = r_dinb;
    assign enb           = r_enb;
    assign web           = r_web;
    assign STORE_BUSY    = r_busy;
    assign STORE_DONE    = r_done;
    assign WORDS_WRITTEN = r_words;

endmodule
`default_nettype wire

// File: tb/tb_pe_store_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_store_writeback
// Purpose  : Self-checking bench for pe_store_writeback with a BRAM model
//            and a per-cycle expected trace derived from the command.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_store_writeback;

`ifdef STORE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic        CLK;
    logic        RST;
    logic        STORE_START;
    logic [31:0] BASE_ADDR;
    logic [3:0]  PE_MASK;
    logic [31:0] PE_DOUT_0, PE_DOUT_1, PE_DOUT_2, PE_DOUT_3;
    logic [31:0] addrb;
    logic [31:0] dinb;
    logic [31:0] doutb;
    logic        enb;
    logic [3:0]  web;
    logic        STORE_BUSY;
    logic        STORE_DONE;
    logic [2:0]  WORDS_WRITTEN;
    logic        VERIFY_ERR;

    int n_checks = 0;
    int n_errors = 0;

    // BRAM model state; a single address may be made to read back corrupted
    logic [31:0] mem [logic [31:0]];
    logic [31:0] corrupt_addr = 32'h0;
    bit          corrupt_en   = 1'b0;

    pe_store_writeback #(.DATA_W(32), .ADDR_W(32)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .STORE_START   (STORE_START),
        .BASE_ADDR     (BASE_ADDR),
        .PE_MASK       (PE_MASK),
        .PE_DOUT_0     (PE_DOUT_0),
        .PE_DOUT_1     (PE_DOUT_1),
        .PE_DOUT_2     (PE_DOUT_2),
        .PE_DOUT_3     (PE_DOUT_3),
        .addrb         (addrb),
        .dinb          (dinb),
        .doutb         (doutb),
        .enb           (enb),
        .web           (web),
        .STORE_BUSY    (STORE_BUSY),
        .STORE_DONE    (STORE_DONE),
        .WORDS_WRITTEN (WORDS_WRITTEN),
        .VERIFY_ERR    (VERIFY_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Port-B BRAM: write on web, registered read with one cycle of latency
    always @(posedge CLK) begin
        logic [31:0] rd;
        if (enb) begin
            rd = mem.exists(addrb) ? mem[addrb] : 32'h0;
            if (corrupt_en && addrb == corrupt_addr) rd = rd ^ 32'h0000_0001;
            if (web != 4'b0000) mem[addrb] = dinb;
            doutb <= rd;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one command and compare every output on every cycle against the
    // trace that follows from the command: enabled PEs in ascending order at
    // consecutive addresses, optional readback, then one DONE cycle.
    task automatic run_cmd(input logic [3:0] mask, input logic [31:0] base,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3,
                           input bit scramble, input string name);
        logic [31:0] words [4];
        logic [31:0] exp_addr [$];
        logic [31:0] exp_data [$];
        int          n;
        int          dcyc;
        bit          exp_err;
        logic        e_enb, e_busy, e_done;
        logic [3:0]  e_web;
        logic [31:0] e_addr, e_din;
        logic [2:0]  e_words;
        words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                exp_addr.push_back(base + 32'(exp_addr.size()));
                exp_data.push_back(words[i]);
            end
        end
        n = exp_addr.size();
        dcyc = (n == 0) ? 1 : (VERIFY ? 2 * n + 2 : n + 1);
        exp_err = 1'b0;
        if (VERIFY && corrupt_en) begin
            foreach (exp_addr[j]) if (exp_addr[j] == corrupt_addr) exp_err = 1'b1;
        end

        @(negedge CLK);
        STORE_START = 1'b1;
        PE_MASK     = mask;
        BASE_ADDR   = base;
        PE_DOUT_0 = w0; PE_DOUT_1 = w1; PE_DOUT_2 = w2; PE_DOUT_3 = w3;
        tick();
        STORE_START = 1'b0;
        for (int c = 1; c <= dcyc + 1; c++) begin
            if (c <= n) begin
                e_enb = 1'b1; e_web = 4'hF; e_addr = exp_addr[c-1];
                e_din = exp_data[c-1]; e_words = 3'(c - 1);
            end else if (VERIFY && n > 0 && c <= 2 * n) begin
                e_enb = 1'b1; e_web = 4'h0; e_addr = exp_addr[c-n-1];
                e_din = 32'h0; e_words = 3'(n);
            end else begin
                e_enb = 1'b0; e_web = 4'h0; e_addr = 32'h0;
                e_din = 32'h0; e_words = 3'(n);
            end
            e_busy = (c <= dcyc);
            e_done = (c == dcyc);
            check($sformatf("%s c%0d enb", name, c), 64'(enb), 64'(e_enb));
            check($sformatf("%s c%0d web", name, c), 64'(web), 64'(e_web));
            check($sformatf("%s c%0d addrb", name, c), 64'(addrb), 64'(e_addr));
            check($sformatf("%s c%0d dinb", name, c), 64'(dinb), 64'(e_din));
            check($sformatf("%s c%0d busy", name, c), 64'(STORE_BUSY), 64'(e_busy));
            check($sformatf("%s c%0d done", name, c), 64'(STORE_DONE), 64'(e_done));
            check($sformatf("%s c%0d words", name, c), 64'(WORDS_WRITTEN), 64'(e_words));
            if (c <= n + 1 || c >= dcyc)
                check($sformatf("%s c%0d verr", name, c), 64'(VERIFY_ERR), 64'(exp_err));
            if (scramble) begin
                PE_DOUT_0 = $urandom; PE_DOUT_1 = $urandom;
                PE_DOUT_2 = $urandom; PE_DOUT_3 = $urandom;
            end
            tick();
        end
        foreach (exp_addr[j]) begin
            check($sformatf("%s mem[%0h]", name, exp_addr[j]),
                  64'(mem.exists(exp_addr[j]) ? mem[exp_addr[j]] : 32'hDEAD_BEEF),
                  64'(exp_data[j]));
        end
    endtask

    initial begin
        int          k;
        logic [31:0] r0, r1, r2, r3;
        RST = 1'b1; STORE_START = 1'b0; BASE_ADDR = 32'h0; PE_MASK = 4'h0;
        PE_DOUT_0 = 32'h0; PE_DOUT_1 = 32'h0; PE_DOUT_2 = 32'h0; PE_DOUT_3 = 32'h0;
        doutb = 32'h0;

        // Reset state
        repeat (3) tick();
        check("rst enb", 64'(enb), 64'(0));
        check("rst web", 64'(web), 64'(0));
        check("rst addrb", 64'(addrb), 64'(0));
        check("rst dinb", 64'(dinb), 64'(0));
        check("rst busy", 64'(STORE_BUSY), 64'(0));
        check("rst done", 64'(STORE_DONE), 64'(0));
        check("rst words", 64'(WORDS_WRITTEN), 64'(0));
        check("rst verr", 64'(VERIFY_ERR), 64'(0));
        RST = 1'b0;
        tick();

        // Reset mid-command: four-word store interrupted in cycle 2
        @(negedge CLK);
        STORE_START = 1'b1; PE_MASK = 4'hF; BASE_ADDR = 32'h40;
        PE_DOUT_0 = 32'hB0; PE_DOUT_1 = 32'hB1; PE_DOUT_2 = 32'hB2; PE_DOUT_3 = 32'hB3;
        tick();
        STORE_START = 1'b0;
        check("rstmid c1 enb", 64'(enb), 64'(1));
        tick();
        check("rstmid c2 addrb", 64'(addrb), 64'(32'h41));
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rstmid c3 enb", 64'(enb), 64'(0));
        check("rstmid c3 web", 64'(web), 64'(0));
        check("rstmid c3 busy", 64'(STORE_BUSY), 64'(0));
        check("rstmid c3 words", 64'(WORDS_WRITTEN), 64'(0));
        check("rstmid c3 addrb", 64'(addrb), 64'(0));
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rstmid +%0d done", i), 64'(STORE_DONE), 64'(0));
            check($sformatf("rstmid +%0d enb", i), 64'(enb), 64'(0));
        end
        check("rstmid no write 0x42", 64'(mem.exists(32'h42)), 64'(0));
        check("rstmid wrote 0x41", 64'(mem.exists(32'h41) ? mem[32'h41] : 32'h0), 64'(32'hB1));

        // Reset and start in the same cycle: command dropped
        @(negedge CLK);
        RST = 1'b1; STORE_START = 1'b1; PE_MASK = 4'hF; BASE_ADDR = 32'h70;
        tick();
        RST = 1'b0; STORE_START = 1'b0;
        check("rst+start busy", 64'(STORE_BUSY), 64'(0));
        tick();
        check("rst+start busy2", 64'(STORE_BUSY), 64'(0));
        check("rst+start enb2", 64'(enb), 64'(0));

        // Full and sparse masks
        run_cmd(4'b1111, 32'h10, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1'b0, "full");
        run_cmd(4'b1010, 32'h20, $urandom, $urandom, $urandom, $urandom, 1'b0, "sparse");

        // Empty mask, start held through DONE is ignored, next IDLE start taken
        @(negedge CLK);
        STORE_START = 1'b1; PE_MASK = 4'b0000; BASE_ADDR = 32'h30;
        tick();
        check("empty c1 done", 64'(STORE_DONE), 64'(1));
        check("empty c1 busy", 64'(STORE_BUSY), 64'(1));
        check("empty c1 enb", 64'(enb), 64'(0));
        check("empty c1 words", 64'(WORDS_WRITTEN), 64'(0));
        PE_MASK = 4'b0001; BASE_ADDR = 32'h50; PE_DOUT_0 = 32'h55;
        tick();
        check("empty c2 busy", 64'(STORE_BUSY), 64'(0));
        check("empty c2 done", 64'(STORE_DONE), 64'(0));
        check("empty c2 enb", 64'(enb), 64'(0));
        tick();
        STORE_START = 1'b0;
        check("second c1 enb", 64'(enb), 64'(1));
        check("second c1 addrb", 64'(addrb), 64'(32'h50));
        check("second c1 dinb", 64'(dinb), 64'(32'h55));
        check("second c1 busy", 64'(STORE_BUSY), 64'(1));
        k = 1;
        while (!STORE_DONE && k < 12) begin
            tick();
            k++;
        end
        check("second done cycle", 64'(k), 64'(VERIFY ? 4 : 2));
        check("second words", 64'(WORDS_WRITTEN), 64'(1));
        tick();

        // Snapshot isolation and address wrap
        run_cmd(4'b0011, 32'hFFFF_FFFF, $urandom, $urandom, $urandom, $urandom, 1'b1, "wrap");
        check("wrap low addr", 64'(mem.exists(32'h0)), 64'(1));

`ifdef STORE_VERIFY_EN
        // Readback with a corrupted word, then a clean rerun
        corrupt_addr = 32'h61;
        corrupt_en   = 1'b1;
        run_cmd(4'b1111, 32'h60, $urandom, $urandom, $urandom, $urandom, 1'b0, "vcorrupt");
        corrupt_en   = 1'b0;
        run_cmd(4'b1111, 32'h60, $urandom, $urandom, $urandom, $urandom, 1'b0, "vclean");
`endif

        // Randomized commands
        for (int t = 0; t < 12; t++) begin
            r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
            run_cmd(4'($urandom_range(0, 15)), $urandom, r0, r1, r2, r3,
                    1'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pe_store_writeback.md
# pe_store_writeback

Downstream writeback stage for the four-PE SIMD array. It snapshots the four PE result words on a single store command and writes the PE-enabled ones into data BRAM port B at consecutive addresses, one word per clock. A single STORE instruction therefore replaces the per-PE store sequence. The block raises a done pulse for the control unit when it finishes.

## Interface
- `DATA_W`, default 32: PE word and BRAM data width.
- `ADDR_W`, default 32: BRAM address width.

- `CLK`  in  1  system clock; all logic on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `STORE_START`  in  1  store command. Sampled only in IDLE.
- `BASE_ADDR`  in  ADDR_W  first destination address. Captured on accept.
- `PE_MASK`  in  4  bit i set = store PE i. Captured on accept.
- `PE_DOUT_0..PE_DOUT_3`  in  DATA_W each  PE result words. Captured on accept.
- `addrb`  out  ADDR_W  BRAM port B address.
- `dinb`  out  DATA_W  BRAM port B write data.
- `doutb`  in  DATA_W  BRAM port B read data. Used only with `STORE_VERIFY_EN`.
- `enb`  out  1  BRAM port B enable.
- `web`  out  4  BRAM byte write enables.
- `STORE_BUSY`  out  1  high from the cycle after accept through the DONE cycle.
- `STORE_DONE`  out  1  one-cycle completion pulse.
- `WORDS_WRITTEN`  out  3  count of words written by the last command (0–4). Held until the next accept.
- `VERIFY_ERR`  out  1  readback mismatch flag. Held until the next accept.

## Operation
- States: IDLE, WRITE, VERIFY_RD (macro only), VERIFY_CMP (macro only), DONE.
- IDLE with `STORE_START=1`: accept the command.
  - Capture `PE_DOUT_0..3` into snapshot registers.
  - Capture `BASE_ADDR` and `PE_MASK`.
  - Clear the word index k, `WORDS_WRITTEN` and `VERIFY_ERR`.
  - Next state is WRITE, or DONE if `PE_MASK==0`.
- WRITE: select the lowest-numbered pending mask bit i.
  - Drive `enb=1`, `web=4'b1111`, `addrb=snapBASE+k`, `dinb=snap[i]`.
  - Clear bit i from the pending mask; k and `WORDS_WRITTEN` each increment by 1.
  - When the pending mask becomes empty, go to DONE, or to VERIFY_RD with the macro.
- Packing is compact:
  - Enabled PEs occupy consecutive addresses in ascending PE order.
  - Disabled PEs take no cycles and no addresses.
- Address arithmetic is modulo 2^ADDR_W; BASE+k wraps silently.
- DONE: `STORE_DONE=1` for exactly one cycle, then return to IDLE.
- Outside WRITE and verify reads: `enb=0`, `web=0`, `addrb=0`, `dinb=0`.
- `STORE_START` while not in IDLE is ignored; it is not queued.
- PE output changes after accept do not affect the written data.

## Timing
- All BRAM-side outputs and status outputs are registered.
- Accept happens at edge 0. Words are written at edges 1..N, where N = popcount(`PE_MASK`). `STORE_DONE` is high in cycle N+1.
- With `PE_MASK=0`, `STORE_DONE` is high in cycle 1 and nothing is written.
- Back-to-back commands: `STORE_START` held high during DONE is not accepted. The next accept is possible in the first IDLE cycle after DONE.
- BRAM read latency is 1 cycle. Read data presented on `doutb` in cycle t+1 belongs to the address driven in cycle t.
- Reset values: `addrb=0`, `dinb=0`, `enb=0`, `web=0`, `STORE_BUSY=0`, `STORE_DONE=0`, `WORDS_WRITTEN=0`, `VERIFY_ERR=0`, state IDLE.
- `RST` mid-command: next cycle returns to IDLE with all outputs at reset values. No further writes occur and no `STORE_DONE` is generated.
- `RST` and `STORE_START` in the same cycle: reset wins and the command is dropped.

## Configuration
- Macro `STORE_VERIFY_EN`.
- Defined: after the last write, read back all N words.
  - VERIFY_RD: issue reads at BASE+0..N-1, one per cycle, with `enb=1` and `web=0`.
  - Compare each returned word, one cycle later, against the matching snapshot word.
  - VERIFY_CMP is the final compare cycle.
  - Any mismatch sets `VERIFY_ERR`, which stays set until the next accept.
  - `STORE_DONE` moves to cycle 2N+2. With N=0 no readback is done and `STORE_DONE` stays at cycle 1.
- Undefined: no verify states; `doutb` is ignored; `VERIFY_ERR` is tied to 0.

## Test plan
- Full mask: mask=4'b1111, BASE=0x10, PE words 0xA0..0xA3. Expect writes 0x10←0xA0, 0x11←0xA1, 0x12←0xA2, 0x13←0xA3 at cycles 1–4; DONE at cycle 5; `WORDS_WRITTEN=4`.
- Sparse mask: mask=4'b1010, BASE=0x20. Expect 0x20←PE1 and 0x21←PE3; DONE at cycle 3; `WORDS_WRITTEN=2`.
- Empty mask, then a second start: mask=0. Expect no `enb`, DONE at cycle 1. A second start asserted during DONE is ignored; a start in the following IDLE cycle is accepted.
- Snapshot and wrap: BASE=0xFFFFFFFF with mask=4'b0011, changing `PE_DOUT` every cycle after accept. Expect addresses 0xFFFFFFFF then 0x00000000, each holding the captured value.
- Reset mid-command: `RST` asserted at cycle 2 of a 4-word store. Expect `enb`, `web`, `STORE_BUSY` and `WORDS_WRITTEN` at 0 from cycle 3, and no `STORE_DONE`.
- With `STORE_VERIFY_EN`: the BRAM model corrupts the word at BASE+1. Expect `VERIFY_ERR=1` and DONE at cycle 10 for N=4. A clean rerun gives `VERIFY_ERR=0`.
